// File: rtl/l0_feeder.sv
// Activation feeder: streams a job of words from SRAM into the L0 FIFO bank
// through a one-entry skid register, then drives the staggered row read and flush.
module l0_feeder #(
  parameter int row    = 8,
  parameter int bw     = 4,
  parameter int addr_w = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addr_w-1:0]   base_addr,
  input  logic [6:0]          len,
  output logic                sram_cen,
  output logic                sram_wen,
  output logic [addr_w-1:0]   sram_addr,
  input  logic [row*bw-1:0]   sram_q,
  output logic                l0_wr,
  output logic [row*bw-1:0]   l0_in,
  input  logic                l0_full,
  output logic                l0_rd,
  output logic                busy,
  output logic                done
);

  localparam int dw    = row * bw;
  localparam int cnt_w = $clog2((row > 64 ? row : 64) + 1);

  localparam logic [1:0] s_idle  = 2'd0;
  localparam logic [1:0] s_fill  = 2'd1;
  localparam logic [1:0] s_drain = 2'd2;
  localparam logic [1:0] s_flush = 2'd3;

  logic [1:0]        state;
  logic [addr_w-1:0] base;
  logic [6:0]        len_q;
  logic [6:0]        issued;
  logic [6:0]        written;
  logic [cnt_w-1:0]  cnt;
  logic              pend;
  logic              skid_v;
  logic [dw-1:0]     skid_d;
  logic              done_q;

  logic              fill;
  logic              issue;
  logic              wr_skid;
  logic              wr_ret;
  logic              cap;
  logic [6:0]        written_nxt;

  // Read issue and write-back decisions; returning data goes to the skid when it cannot be written.
  always_comb begin
    fill        = (state == s_fill);
    issue       = fill && (issued < len_q) && !l0_full && !skid_v;
    wr_skid     = fill && skid_v && !l0_full;
    wr_ret      = fill && pend && !skid_v && !l0_full;
    cap         = fill && pend && !wr_ret;
    written_nxt = written + {6'd0, (wr_skid | wr_ret)};
  end

  // Output drive derived from state and the decisions above.
  always_comb begin
    sram_cen  = !issue;
    sram_wen  = 1'b1;
    sram_addr = base + addr_w'(issued);
    l0_wr     = wr_skid | wr_ret;
    if (skid_v) begin
      l0_in = skid_d;
    end else begin
      l0_in = sram_q;
    end
    l0_rd = (state == s_drain);
    busy  = (state != s_idle);
    done  = done_q;
  end

  // Datapath counters and skid register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend    <= 1'b0;
      skid_v  <= 1'b0;
      skid_d  <= '0;
      issued  <= 7'd0;
      written <= 7'd0;
    end else begin
      pend <= issue;
      if (start && (state == s_idle)) begin
        issued  <= 7'd0;
        written <= 7'd0;
      end else begin
        if (issue) begin
          issued <= issued + 7'd1;
        end else begin
          issued <= issued;
        end
        written <= written_nxt;
      end
      if (cap) begin
        skid_v <= 1'b1;
        skid_d <= sram_q;
      end else if (wr_skid) begin
        skid_v <= 1'b0;
      end else begin
        skid_v <= skid_v;
      end
    end
  end

  // Job sequencing: IDLE -> FILL -> DRAIN (len cycles) -> FLUSH (row cycles) -> done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= s_idle;
      base   <= '0;
      len_q  <= 7'd0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        s_idle: begin
          if (start) begin
            base  <= base_addr;
            len_q <= len;
            cnt   <= '0;
            if (len != 7'd0) begin
              state <= s_fill;
            end else begin
              done_q <= 1'b1;
            end
          end else begin
            state <= s_idle;
          end
        end
        s_fill: begin
          if (written_nxt == len_q) begin
            state <= s_drain;
            cnt   <= '0;
          end else begin
            state <= s_fill;
          end
        end
        s_drain: begin
          if (cnt == cnt_w'(len_q - 7'd1)) begin
            state <= s_flush;
            cnt   <= '0;
          end else begin
            cnt <= cnt + cnt_w'(1);
          end
        end
        s_flush: begin
          if (cnt == cnt_w'(row - 1)) begin
            state  <= s_idle;
            cnt    <= '0;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt + cnt_w'(1);
          end
        end
        default: begin
          state <= s_idle;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
